dxm_interrupt_ctrl: RTL
=======================

// Module: dxm_interrupt_ctrl
// PURPOSE
//  Multi-output interrupt aggregator for the TRNG/CC register block. Latches per-source events (edge or level),
//  supports write-1-to-clear, per-output masking, and per-output interrupt coalescing (count threshold + timeout).
//  Drives NUM_OUT interrupt lines to the system interrupt controller.
// PARAMETERS
//  VEC_W    8  number of interrupt sources
//  NUM_OUT  2  number of interrupt request outputs
//  CNT_W    8  width of coalescing threshold, timeout and internal counters
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              asynchronous active-low reset
//  src_in         in   VEC_W          source lines, synchronous to clk
//  mode           in   VEC_W          per-source: 0 = edge (sticky), 1 = level (follows src_in)
//  clr_status_1p  in   1              one-cycle clear strobe
//  r_din          in   VEC_W          clear vector, write-1-to-clear, qualified by clr_status_1p
//  mask           in   NUM_OUT*VEC_W  slice k = mask for output k; 1 = source masked
//  coal_thr       in   CNT_W          new-event count that asserts int_req; 0 or 1 = no coalescing
//  coal_tmo       in   CNT_W          max cycles in ACCUM before forced assert; 0 = timeout disabled
//  status         out  VEC_W          latched status
//  pend           out  NUM_OUT        combinational |(status & ~mask_k)
//  int_req        out  NUM_OUT        interrupt request, registered
// BEHAVIOUR
//  Reset: status=0, int_req=0, src_d=0, all FSMs IDLE, cnt=0, tmr=0.
//  Edge detect: edge_ev = src_in & ~src_d & ~mode.
//   src_d resets to 0, so a source already high at reset release produces one event in the first cycle.
//  set_vec = edge_ev | (mode & src_in).
//  Edge bits: status <= (status & ~(clr_status_1p ? r_din : 0)) | edge_ev. A set wins over a simultaneous clear.
//  Level bits: status <= src_in; clears are ignored.
//  Per output k: new_k = |(set_vec & ~status & ~mask_k), i.e. any enabled bit rising this cycle.
//   Several bits rising in the same cycle count as one event.
//  Legacy mode (coal_thr <= 1): int_req[k] <= pend[k]; FSM held in IDLE.
//   Latency: source edge sampled in cycle t -> status high at t+1 -> int_req high at t+2.
//  Coalescing mode (coal_thr >= 2), per-output FSM:
//   IDLE:   on new_k or pend[k] -> ACCUM, cnt <= 1, tmr <= 0.
//   ACCUM:  tmr <= tmr+1 (saturating); on new_k, cnt <= cnt+1 (saturating at all-ones).
//           -> ASSERT if (cnt + new_k) >= coal_thr, or if (coal_tmo != 0 && tmr+1 >= coal_tmo).
//           -> IDLE if pend[k]==0 && !new_k (software cleared everything); counters are zeroed.
//           ASSERT takes priority over IDLE.
//   ASSERT: int_req[k] = 1.
//           -> IDLE (cnt=0, tmr=0) when pend[k]==0 && !new_k.
//  int_req[k] in coalescing mode is decoded from the registered state, so it is glitch-free.
//  coal_thr, coal_tmo and mask are compared live each cycle. Changing them mid-ACCUM takes effect on the next edge.
//  A change of coal_thr across the <=1 / >=2 boundary forces that output's FSM to IDLE on the next edge.
//  Outputs are independent; one source may feed several outputs.
//  Asserting rst_n mid-operation returns everything to reset values immediately.
// TESTING
//  1. thr=0, source 2 edge at cycle 0, mask=0 -> status[2]=1 at cycle 1, int_req[0]=1 at cycle 2;
//     clear r_din=8'h04 -> status 0 next cycle, int_req 0 the cycle after.
//  2. thr=3, tmo=0, edges on src 0/1/3 at cycles 0/2/4 -> int_req[0] stays 0 through cycle 4, rises at cycle 5.
//  3. thr=4, tmo=5, single edge at cycle 0 -> ACCUM from cycle 1, int_req high at cycle 6.
//  4. Edge on src 5 in the same cycle as clr_status_1p with r_din=8'h20 -> status[5] stays 1.
//  5. mode[1]=1, src_in[1] high for 3 cycles then low, clr ignored -> status[1] tracks src_in with 1-cycle delay.
//  6. mask slice 1 = 8'hFF, mask slice 0 = 0, events on all sources -> int_req=2'b01.
//     Then unmask output 1 -> int_req[1] asserts via IDLE->ACCUM (pend) per coal_thr.
//     Drop rst_n while in ACCUM -> all outputs 0.

Source files
------------

// File: rtl/dxm_interrupt_ctrl.sv
// Interrupt aggregator for the TRNG/CC register block: latches edge/level source events,
// supports write-1-to-clear, and drives NUM_OUT masked, optionally coalesced, request lines.
module dxm_interrupt_ctrl #(
    parameter int VEC_W   = 8,
    parameter int NUM_OUT = 2,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [VEC_W-1:0]         src_in,
    input  logic [VEC_W-1:0]         mode,
    input  logic                     clr_status_1p,
    input  logic [VEC_W-1:0]         r_din,
    input  logic [NUM_OUT*VEC_W-1:0] mask,
    input  logic [CNT_W-1:0]         coal_thr,
    input  logic [CNT_W-1:0]         coal_tmo,
    output logic [VEC_W-1:0]         status,
    output logic [NUM_OUT-1:0]       pend,
    output logic [NUM_OUT-1:0]       int_req
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ASSERT
    } state_e;

    logic [VEC_W-1:0]   src_d_q;
    logic [VEC_W-1:0]   status_q, status_d;
    logic [VEC_W-1:0]   edge_ev, set_vec, clr_vec;
    logic [NUM_OUT-1:0] new_ev;
    logic [NUM_OUT-1:0] int_req_q, int_req_d;
    logic               legacy;

    state_e             state_q [NUM_OUT];
    state_e             state_d [NUM_OUT];
    logic [CNT_W-1:0]   cnt_q   [NUM_OUT];
    logic [CNT_W-1:0]   cnt_d   [NUM_OUT];
    logic [CNT_W-1:0]   tmr_q   [NUM_OUT];
    logic [CNT_W-1:0]   tmr_d   [NUM_OUT];
    logic [CNT_W:0]     cnt_sum [NUM_OUT];
    logic [CNT_W:0]     tmr_inc [NUM_OUT];

    assign legacy  = (coal_thr <= CNT_W'(1));
    assign edge_ev = src_in & ~src_d_q & ~mode;
    assign set_vec = edge_ev | (mode & src_in);
    assign clr_vec = clr_status_1p ? r_din : '0;

    // Level bits mirror the source; edge bits are sticky and a new edge beats a same-cycle clear.
    assign status_d = (mode & src_in) | (~mode & ((status_q & ~clr_vec) | edge_ev));

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            pend[k]   = |(status_q & ~mask[k*VEC_W +: VEC_W]);
            new_ev[k] = |(set_vec & ~status_q & ~mask[k*VEC_W +: VEC_W]);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            state_d[k]   = state_q[k];
            cnt_d[k]     = cnt_q[k];
            tmr_d[k]     = tmr_q[k];
            cnt_sum[k]   = {1'b0, cnt_q[k]} + (CNT_W+1)'(new_ev[k]);
            tmr_inc[k]   = {1'b0, tmr_q[k]} + (CNT_W+1)'(1);
            int_req_d[k] = 1'b0;

            if (legacy) begin
                state_d[k] = ST_IDLE;
                cnt_d[k]   = '0;
                tmr_d[k]   = '0;
            end else begin
                case (state_q[k])
                    ST_IDLE: begin
                        if (new_ev[k] || pend[k]) begin
                            state_d[k] = ST_ACCUM;
                            cnt_d[k]   = CNT_W'(1);
                            tmr_d[k]   = '0;
                        end
                    end
                    ST_ACCUM: begin
                        if (tmr_q[k] != '1) tmr_d[k] = tmr_q[k] + CNT_W'(1);
                        if (new_ev[k] && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        if ((cnt_sum[k] >= {1'b0, coal_thr}) ||
                            ((coal_tmo != '0) && (tmr_inc[k] >= {1'b0, coal_tmo}))) begin
                            state_d[k] = ST_ASSERT;
                        end else if (!pend[k] && !new_ev[k]) begin
                            state_d[k] = ST_IDLE;
                            cnt_d[k]   = '0;
                            tmr_d[k]   = '0;
                        end
                    end
                    ST_ASSERT: begin
                        if (!pend[k] && !new_ev[k]) begin
                            state_d[k] = ST_IDLE;
                            cnt_d[k]   = '0;
                            tmr_d[k]   = '0;
                        end
                    end
                    default: begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                        tmr_d[k]   = '0;
                    end
                endcase
            end

            // Registering the decode of the next state keeps the request glitch-free.
            int_req_d[k] = legacy ? pend[k] : (state_d[k] == ST_ASSERT);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d_q   <= '0;
            status_q  <= '0;
            int_req_q <= '0;
            // NOTE: per-output counters are a handful of flops, not a memory, so all are reset.
            for (int k = 0; k < NUM_OUT; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
                tmr_q[k]   <= '0;
            end
        end else begin
            src_d_q   <= src_in;
            status_q  <= status_d;
            int_req_q <= int_req_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                tmr_q[k]   <= tmr_d[k];
            end
        end
    end

    assign status  = status_q;
    assign int_req = int_req_q;

endmodule
